// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
//
// SPI bus master. Serializes a DATA_WIDTH-bit word onto dout (MSB first) and
// captures the same number of bits from din, driving csb and sclk under
// runtime-selectable CPOL/CPHA.
//
// Parameters
//   DATA_WIDTH  word length in bits (>= 2)
//   CLK_DIV     clk cycles per sclk half-period (>= 1)
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   CPOL   in   sclk idle level (hold stable while busy)
//   CPHA   in   0: sample on leading edge, 1: sample on trailing edge
//   start  in   request pulse, accepted only in IDLE
//   datai  in   transmit word, latched when start is accepted
//   datao  out  received word, valid from done until the next done
//   busy   out  high from acceptance until done, inclusive
//   done   out  one-cycle completion pulse
//   csb    out  active-low chip select
//   sclk   out  serial clock = CPOL ^ phase
//   dout   out  MOSI = transmit shift register MSB
//   din    in   MISO
//   hold   in   (only with SPI_MASTER_CSB_HOLD_EN) keep csb low after word
//
// Optional feature macro: SPI_MASTER_CSB_HOLD_EN
//   Adds the hold input. When hold=1 in the HOLD-state tick cycle, csb stays
//   low into IDLE and the next accepted start goes straight to SHIFT.
//
// Handshake: start is a level sampled on each rising edge; it is taken only
// when the FSM is in IDLE, anything else is dropped (never queued). done is a
// single-cycle pulse, and datao is stable from done until the next done.
// ---------------------------------------------------------------------------
module spi_master #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] datai,
    output logic [DATA_WIDTH-1:0] datao,
    output logic                  busy,
    output logic                  done,
    output logic                  csb,
    output logic                  sclk,
    output logic                  dout,
    input  logic                  din
`ifdef SPI_MASTER_CSB_HOLD_EN
    ,
    input  logic                  hold
`endif
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [EW-1:0]         r_edge;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_datao;
    logic                  r_phase;
    logic                  r_csb;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_tick;
    logic                  w_lead;
    logic                  w_first;
    logic                  w_last;
    logic                  w_hold;
    logic [DATA_WIDTH-1:0] w_tx_shl;
    logic [DATA_WIDTH-1:0] w_rx_shl;

`ifdef SPI_MASTER_CSB_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    assign w_tick   = (r_cnt == CW'(CLK_DIV - 1));
    // r_edge counts toggles already made; the next toggle is odd (leading)
    // when that count is even.
    assign w_lead   = ~r_edge[0];
    assign w_first  = (r_edge == '0);
    assign w_last   = (r_edge == EW'(2 * DATA_WIDTH - 1));
    assign w_tx_shl = {r_tx[DATA_WIDTH-2:0], 1'b0};
    assign w_rx_shl = {r_rx[DATA_WIDTH-2:0], din};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_edge  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_datao <= '0;
            r_phase <= 1'b0;
            r_csb   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_cnt  <= (r_state == S_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_phase <= 1'b0;
                    if (start) begin
                        r_tx   <= datai;
                        r_rx   <= '0;
                        r_edge <= '0;
                        r_busy <= 1'b1;
                        r_csb  <= 1'b0;
                        // csb can only still be low here after a held word;
                        // the slave is already selected, so skip SETUP.
                        r_state <= r_csb ? S_SETUP : S_SHIFT;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (w_tick) r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        r_phase <= ~r_phase;
                        r_edge  <= r_edge + 1'b1;
                        if (w_lead) begin
                            if (!CPHA)         r_rx <= w_rx_shl;
                            else if (!w_first) r_tx <= w_tx_shl;
                        end else begin
                            if (CPHA)          r_rx <= w_rx_shl;
                            else if (!w_last)  r_tx <= w_tx_shl;
                        end
                        if (w_last) r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_csb   <= ~w_hold;
                        r_datao <= r_rx;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign datao = r_datao;
    assign busy  = r_busy;
    assign done  = r_done;
    assign csb   = r_csb;
    assign sclk  = CPOL ^ r_phase;
    assign dout  = r_tx[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  localparam int W_A  = 16;
  localparam int D_A  = 2;
  localparam int W_B  = 2;
  localparam int D_B  = 1;
  localparam int DT_A = (2 * W_A + 2) * D_A;  // acceptance edge to done edge
  localparam int DT_B = (2 * W_B + 2) * D_B;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic cpol, cpha;

  // DUT A: 16-bit, CLK_DIV=2
  logic             start_a, busy_a, done_a, csb_a, sclk_a, dout_a, din_a, lb_a;
  logic [W_A-1:0]   datai_a, datao_a;
  // DUT B: 2-bit, CLK_DIV=1, always loopback
  logic             start_b, busy_b, done_b, csb_b, sclk_b, dout_b, din_b;
  logic [W_B-1:0]   datai_b, datao_b;
`ifdef SPI_MASTER_CSB_HOLD_EN
  logic             hold_a;
  logic             hold_b;
`endif

  // bench-side SPI slave attached to DUT A
  logic [15:0] s_datai, s_tx, s_rx;
  logic        s_sclk_q, s_first, s_miso;

  assign din_a  = lb_a ? dout_a : s_miso;
  assign din_b  = dout_b;
  assign s_miso = s_tx[15];

  spi_master #(.DATA_WIDTH(W_A), .CLK_DIV(D_A)) u_dut_a (
    .clk(clk), .reset(reset), .CPOL(cpol), .CPHA(cpha), .start(start_a),
    .datai(datai_a), .datao(datao_a), .busy(busy_a), .done(done_a),
    .csb(csb_a), .sclk(sclk_a), .dout(dout_a), .din(din_a)
`ifdef SPI_MASTER_CSB_HOLD_EN
    , .hold(hold_a)
`endif
  );

  spi_master #(.DATA_WIDTH(W_B), .CLK_DIV(D_B)) u_dut_b (
    .clk(clk), .reset(reset), .CPOL(cpol), .CPHA(cpha), .start(start_b),
    .datai(datai_b), .datao(datao_b), .busy(busy_b), .done(done_b),
    .csb(csb_b), .sclk(sclk_b), .dout(dout_b), .din(din_b)
`ifdef SPI_MASTER_CSB_HOLD_EN
    , .hold(hold_b)
`endif
  );

  // Slave: MISO changes one clk after the master's shift-side edge, MOSI is
  // captured one clk after the master's sample-side edge.
  always @(posedge clk) begin
    s_sclk_q <= sclk_a;
    if (csb_a) begin
      s_tx    <= s_datai;
      s_first <= 1'b1;
    end else if (sclk_a != s_sclk_q) begin
      if (s_sclk_q == cpol) begin
        if (!cpha) s_rx <= {s_rx[14:0], dout_a};
        else if (!s_first) s_tx <= {s_tx[14:0], 1'b0};
        s_first <= 1'b0;
      end else begin
        if (cpha) s_rx <= {s_rx[14:0], dout_a};
        else s_tx <= {s_tx[14:0], 1'b0};
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- driver tasks ----------------
  task automatic set_mode(input int m);
    @(negedge clk);
    cpol = m[1];
    cpha = m[0];
    repeat (3) @(negedge clk);
  endtask

  task automatic xfer_a(input logic [15:0] d, output int dt, output int rises,
                        output int falls, output logic [15:0] got,
                        output logic csb_acc, output logic dout_acc,
                        output logic busy_done, output logic tmo);
    int acc;
    logic prev;
    rises = 0; falls = 0; dt = -1; got = '0; busy_done = 1'b0; tmo = 1'b1;
    @(negedge clk);
    datai_a = d;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    acc = cyc;
    csb_acc = csb_a;
    dout_acc = dout_a;
    prev = sclk_a;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (sclk_a && !prev) rises++;
      if (!sclk_a && prev) falls++;
      prev = sclk_a;
      if (done_a) begin
        dt = cyc - acc;
        got = datao_a;
        busy_done = busy_a;
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic xfer_b(input logic [1:0] d, output int dt, output logic [1:0] got,
                        output logic tmo);
    int acc;
    dt = -1; got = '0; tmo = 1'b1;
    @(negedge clk);
    datai_b = d;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    acc = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_b) begin
        dt = cyc - acc;
        got = datao_b;
        tmo = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    cpol = 1'b1;
    cpha = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (csb_a !== 1'b1) begin n_fail++; $display("FAIL rst_csb_a got %b want 1", csb_a); end
    n_tests++; if (sclk_a !== 1'b1) begin n_fail++; $display("FAIL rst_sclk_a got %b want 1", sclk_a); end
    n_tests++; if (dout_a !== 1'b0) begin n_fail++; $display("FAIL rst_dout_a got %b want 0", dout_a); end
    n_tests++; if (datao_a !== 16'h0) begin n_fail++; $display("FAIL rst_datao_a got %h want 0", datao_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy_a got %b want 0", busy_a); end
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rst_done_a got %b want 0", done_a); end
    n_tests++; if (csb_b !== 1'b1) begin n_fail++; $display("FAIL rst_csb_b got %b want 1", csb_b); end
    n_tests++; if (sclk_b !== 1'b1) begin n_fail++; $display("FAIL rst_sclk_b got %b want 1", sclk_b); end
    n_tests++; if (datao_b !== 2'b00) begin n_fail++; $display("FAIL rst_datao_b got %b want 00", datao_b); end
    reset = 1'b0;
    cpol = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_loopback;
    int dt, r, f;
    logic [15:0] got, want;
    logic ca, da, bd, tmo;
    lb_a = 1'b1;
    for (int m = 0; m < 4; m++) begin
      set_mode(m);
      exp_q.push_back(16'hA5C3);
      xfer_a(16'hA5C3, dt, r, f, got, ca, da, bd, tmo);
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_tests++; if (tmo) begin n_fail++; $display("FAIL loop_timeout mode=%0d no done", m); end
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL loop_datao mode=%0d got %h want %h", m, got, want); end
      n_tests++; if (dt !== DT_A) begin n_fail++; $display("FAIL loop_done_edge mode=%0d got %0d want %0d", m, dt, DT_A); end
      n_tests++; if (r !== W_A || f !== W_A) begin n_fail++; $display("FAIL loop_sclk_edges mode=%0d got rise %0d fall %0d want %0d each", m, r, f, W_A); end
      n_tests++; if (ca !== 1'b0) begin n_fail++; $display("FAIL loop_csb_fall mode=%0d got %b want 0", m, ca); end
      n_tests++; if (da !== 1'b1) begin n_fail++; $display("FAIL loop_dout_msb mode=%0d got %b want 1", m, da); end
      n_tests++; if (bd !== 1'b1) begin n_fail++; $display("FAIL loop_busy_at_done mode=%0d got %b want 1", m, bd); end
      @(negedge clk);
      n_tests++; if (busy_a !== 1'b0 || csb_a !== 1'b1) begin n_fail++; $display("FAIL loop_idle_after mode=%0d got busy %b csb %b want 0 1", m, busy_a, csb_a); end
    end
  endtask

  task automatic test_slave;
    int dt, r, f;
    logic [15:0] got, want;
    logic ca, da, bd, tmo;
    lb_a = 1'b0;
    s_datai = 16'hBEEF;
    for (int m = 0; m < 4; m++) begin
      set_mode(m);
      exp_q.push_back(16'hBEEF);
      xfer_a(16'h1234, dt, r, f, got, ca, da, bd, tmo);
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_tests++; if (tmo) begin n_fail++; $display("FAIL slave_timeout mode=%0d no done", m); end
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL slave_master_rx mode=%0d got %h want %h", m, got, want); end
      n_tests++; if (s_rx !== 16'h1234) begin n_fail++; $display("FAIL slave_slave_rx mode=%0d got %h want 1234", m, s_rx); end
    end
    lb_a = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] d, want;
    int n_exp, n_done, hi_run, n_gap;
    logic seen_low;
    set_mode(0);
    lb_a = 1'b1;
    d = 16'($urandom_range(0, 65535));
    // each word occupies DT_A cycles plus one idle cycle before the restart
    n_exp = (200 + DT_A) / (DT_A + 1);
    for (int k = 0; k < n_exp; k++) exp_q.push_back(d);
    n_done = 0; hi_run = 0; n_gap = 0; seen_low = 1'b0;
    datai_a = d;
    for (int i = 0; i < 500; i++) begin
      start_a = (i < 200);
      @(negedge clk);
      if (done_a) begin
        n_done++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_tests++; if (datao_a !== want) begin n_fail++; $display("FAIL b2b_datao word=%0d got %h want %h", n_done, datao_a, want); end
      end
      if (csb_a) hi_run++;
      else begin
        if (seen_low && hi_run > 0) begin
          n_gap++;
          n_tests++; if (hi_run !== 1) begin n_fail++; $display("FAIL b2b_csb_gap gap=%0d got %0d cycles want 1", n_gap, hi_run); end
        end
        hi_run = 0;
        seen_low = 1'b1;
      end
    end
    start_a = 1'b0;
    n_tests++; if (n_done !== n_exp) begin n_fail++; $display("FAIL b2b_done_count got %0d want %0d", n_done, n_exp); end
    n_tests++; if (n_gap !== n_exp - 1) begin n_fail++; $display("FAIL b2b_gap_count got %0d want %0d", n_gap, n_exp - 1); end
    while (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid;
    int dt, r, f, acc, n_done;
    logic [15:0] got, want;
    logic ca, da, bd, tmo, reached;
    set_mode(2);  // CPOL=1, CPHA=0
    lb_a = 1'b1;
    exp_q.push_back(16'h5A5A);
    xfer_a(16'h5A5A, dt, r, f, got, ca, da, bd, tmo);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL midrst_pre_datao got %h want %h", got, want); end
    @(negedge clk);
    datai_a = 16'hC3C3;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    acc = cyc;
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cyc >= acc + 19 && sclk_a !== cpol) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++; if (!reached) begin n_fail++; $display("FAIL midrst_reach got no sclk active phase want one by edge 20"); end
    reset = 1'b1;
    #1;
    n_tests++; if (csb_a !== 1'b1) begin n_fail++; $display("FAIL midrst_csb got %b want 1", csb_a); end
    n_tests++; if (sclk_a !== cpol) begin n_fail++; $display("FAIL midrst_sclk got %b want %b", sclk_a, cpol); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy_a); end
    n_tests++; if (datao_a !== 16'h0) begin n_fail++; $display("FAIL midrst_datao got %h want 0", datao_a); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done_a || !csb_a) n_done++;
    end
    n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL midrst_quiet got %0d done/csb cycles want 0", n_done); end
  endtask

  task automatic test_small;
    int dt;
    logic [1:0] got, d, want;
    logic tmo;
    for (int m = 0; m < 4; m++) begin
      set_mode(m);
      d = m[0] ? 2'b01 : 2'b10;
      exp_q.push_back({14'h0, d});
      xfer_b(d, dt, got, tmo);
      want = (exp_q.size() > 0) ? 2'(exp_q.pop_front()) : 2'bxx;
      n_tests++; if (tmo) begin n_fail++; $display("FAIL small_timeout mode=%0d no done", m); end
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL small_datao mode=%0d got %b want %b", m, got, want); end
      n_tests++; if (dt !== DT_B) begin n_fail++; $display("FAIL small_done_edge mode=%0d got %0d want %0d", m, dt, DT_B); end
    end
  endtask

`ifdef SPI_MASTER_CSB_HOLD_EN
  task automatic test_csb_hold;
    int n_done, toggles, csb_hi, acc2, first_tog;
    logic prev;
    logic [15:0] got1, got2, want;
    set_mode(0);
    lb_a = 1'b1;
    hold_a = 1'b1;
    exp_q.push_back(16'h00FF);
    exp_q.push_back(16'hFF00);
    n_done = 0; toggles = 0; csb_hi = 0; acc2 = -1; first_tog = -1;
    got1 = '0; got2 = '0;
    @(negedge clk);
    datai_a = 16'h00FF;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    prev = sclk_a;
    for (int i = 0; i < 400 && n_done < 2; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (sclk_a !== prev) begin
        toggles++;
        if (acc2 >= 0 && first_tog < 0) first_tog = cyc - acc2;
      end
      prev = sclk_a;
      if (csb_a && n_done == 0) csb_hi++;
      if (acc2 >= 0 && csb_a && n_done == 1) csb_hi++;
      if (done_a) begin
        n_done++;
        if (n_done == 1) begin
          got1 = datao_a;
          hold_a = 1'b0;
          datai_a = 16'hFF00;
          start_a = 1'b1;
          acc2 = cyc + 1;
        end else begin
          got2 = datao_a;
        end
      end
    end
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_tests++; if (got1 !== want) begin n_fail++; $display("FAIL hold_word1 got %h want %h", got1, want); end
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_tests++; if (got2 !== want) begin n_fail++; $display("FAIL hold_word2 got %h want %h", got2, want); end
    n_tests++; if (csb_hi !== 0) begin n_fail++; $display("FAIL hold_csb_low got %0d high cycles want 0", csb_hi); end
    n_tests++; if (toggles !== 4 * W_A) begin n_fail++; $display("FAIL hold_toggles got %0d want %0d", toggles, 4 * W_A); end
    n_tests++; if (first_tog !== D_A) begin n_fail++; $display("FAIL hold_first_toggle got %0d want %0d", first_tog, D_A); end
    repeat (D_A + 2) @(negedge clk);
    n_tests++; if (csb_a !== 1'b1) begin n_fail++; $display("FAIL hold_release got %b want 1", csb_a); end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    start_a = 1'b0; start_b = 1'b0; datai_a = '0; datai_b = '0; lb_a = 1'b1;
    s_datai = 16'h0; s_tx = '0; s_rx = '0; s_sclk_q = 1'b0; s_first = 1'b1;
`ifdef SPI_MASTER_CSB_HOLD_EN
    hold_a = 1'b0;
    hold_b = 1'b0;
`endif
    test_reset();
    test_loopback();
    test_slave();
    test_back_to_back();
    test_small();
    test_reset_mid();
`ifdef SPI_MASTER_CSB_HOLD_EN
    test_csb_hold();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
